shift_seq_unit: RTL and testbench

- Multi-cycle shift unit that sits downstream of the single-bit shift stage and drives it iteratively.
- Takes one operand, a 5-bit shift amount and an op select, then applies one bit position per clock until the amount is used up.
- Delivers a 32-bit result with a one-cycle ready pulse, in the same handshake style as the multdiv unit.
- Feeds the ALU/execute result mux for the SLL and SRA ops when the single-cycle barrel path is not used.

---
 rtl/shift_seq_unit_pkg.sv | 13 +
 rtl/shift_step_1.sv | 12 +
 rtl/shift_seq_unit.sv | 66 ++++++
 tb/tb_shift_seq_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/shift_seq_unit_pkg.sv
// Shared constants and types for the iterative shift unit.
package shift_seq_unit_pkg;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/shift_step_1.sv
// Single-bit shift step: logical left or arithmetic right by one position.
module shift_step_1
    import shift_seq_unit_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] in,
    input  logic         op,
    output logic [W-1:0] out
);
    assign out = (op == OP_SRA) ? {in[W-1], in[W-1:1]} : {in[W-2:0], 1'b0};
endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: one bit position per clock, ready pulse when done.
module shift_seq_unit
    import shift_seq_unit_pkg::*;
#(
    parameter int WIDTH_P   = WIDTH,
    parameter int SHAMT_W_P = SHAMT_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ctrl_shift,
    input  logic                 ctrl_op,
    input  logic [WIDTH_P-1:0]   data_operandA,
    input  logic [SHAMT_W_P-1:0] ctrl_shamt,
    output logic [WIDTH_P-1:0]   data_result,
    output logic                 data_resultRDY,
    output logic                 busy
);
    state_t               state;
    logic [SHAMT_W_P-1:0] cnt;
    logic                 op_q;
    logic [WIDTH_P-1:0]   step_out;

    shift_step_1 #(.W(WIDTH_P)) u_step (
        .in  (data_result),
        .op  (op_q),
        .out (step_out)
    );

    // busy tracks the cycles in which a shift step is still pending, so a
    // zero-amount operation goes straight to the ready pulse without it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            op_q           <= OP_SLL;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (ctrl_shift) begin
            state          <= ST_RUN;
            cnt            <= ctrl_shamt;
            op_q           <= ctrl_op;
            data_result    <= data_operandA;
            data_resultRDY <= 1'b0;
            busy           <= (ctrl_shamt != '0);
        end else begin
            case (state)
                ST_RUN: begin
                    if (cnt != '0) begin
                        data_result <= step_out;
                        cnt         <= cnt - 1'b1;
                        busy        <= (cnt != SHAMT_W_P'(1));
                    end else begin
                        state          <= ST_IDLE;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                    end
                end
                default: begin
                    data_resultRDY <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: directed vectors, decoupled monitor.
module tb_shift_seq_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_shift;
    logic        ctrl_op;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shamt;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    shift_seq_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_shift     (ctrl_shift),
        .ctrl_op        (ctrl_op),
        .data_operandA  (data_operandA),
        .ctrl_shamt     (ctrl_shamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every ready pulse must match the oldest expected completion.
    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            exp_t e;
            checks++;
            if (busy) begin
                errors++;
                $display("FAIL busy_with_rdy: busy=%0b required 0", busy);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: result=%08h at cycle %0d, none expected", data_result, cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (data_result !== e.res) begin
                    errors++;
                    $display("FAIL result: got %08h required %08h", data_result, e.res);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency: rdy after edge %0d required %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic start(input logic op, input logic [31:0] a, input logic [4:0] sh, output int k);
        @(negedge clock);
        ctrl_shift = 1'b1; ctrl_op = op; data_operandA = a; ctrl_shamt = sh;
        @(posedge clock); #1;
        k = cyc;
        ctrl_shift = 1'b0;
    endtask

    // Waits for the ready pulse, counting busy cycles; optionally scrambles inputs.
    task automatic wait_rdy(input string name, input int sh, input bit rnd);
        int  nb = 0;
        bit  seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clock);
            if (data_resultRDY) seen = 1;
            else if (busy) nb++;
            if (rnd) begin
                data_operandA = $urandom;
                ctrl_shamt    = 5'($urandom_range(0, 31));
                ctrl_op       = 1'($urandom_range(0, 1));
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no rdy within 80 cycles, required one", name);
        end
        checks++;
        if (nb != sh) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d required %0d", name, nb, sh);
        end
    endtask

    task automatic run(input string name, input logic op, input logic [31:0] a,
                       input logic [4:0] sh, input logic [31:0] exp_res, input bit rnd);
        int k;
        start(op, a, sh, k);
        sb.push_back('{res: exp_res, cyc: k + int'(sh) + 1});
        wait_rdy(name, int'(sh), rnd);
    endtask

    initial begin
        int k;
        int nrdy;
        reset = 1'b1; ctrl_shift = 1'b0; ctrl_op = 1'b0;
        data_operandA = '0; ctrl_shamt = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (data_result !== 32'h0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: result=%08h rdy=%0b busy=%0b required 0/0/0",
                     data_result, data_resultRDY, busy);
        end

        run("sll4",    1'b0, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0);
        run("sra31",   1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
        run("sra30",   1'b1, 32'h4000_0000, 5'd30, 32'h0000_0001, 1'b0);
        run("sll0",    1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        run("sra0",    1'b1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        run("sra_neg", 1'b1, 32'hF000_00F0, 5'd4,  32'hFF00_000F, 1'b0);
        run("sll_mix", 1'b0, 32'h1234_5678, 5'd8,  32'h3456_7800, 1'b0);
        run("hold",    1'b0, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1);

        // Restart after two steps: the first operation must never complete.
        start(1'b0, 32'h1, 5'd20, k);
        repeat (2) @(posedge clock);
        run("restart", 1'b0, 32'h3, 5'd2, 32'h0000_000C, 1'b0);

        // Reset in the middle of an SRA.
        start(1'b1, 32'hF000_0000, 5'd16, k);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (data_result !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: result=%08h busy=%0b required 00000000/0", data_result, busy);
        end
        nrdy = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) nrdy++;
        end
        checks++;
        if (nrdy != 0) begin
            errors++;
            $display("FAIL midop_no_rdy: %0d pulses required 0", nrdy);
        end

        run("after_reset", 1'b0, 32'h0000_0003, 5'd1, 32'h0000_0006, 1'b0);

        repeat (3) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
